// File: rtl/heart_pkg.sv
// Shared definitions for the heart-pattern row path: row count,
// default serializer timing and the serializer FSM state encoding.
package heart_pkg;

  localparam int HEART_NUM_ROWS         = 12;
  localparam int DEF_CLK_DIV            = 4;
  localparam int DEF_SAMPLE_PERIOD      = 128;
  localparam int DEF_CNT_W              = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/heart_sample_timer.sv
// Enable-gated modulo counter. o_tick is high for the single cycle in
// which the counter sits at SAMPLE_PERIOD-1 while counting is enabled;
// with enable low the count simply freezes.
module heart_sample_timer
  import heart_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int TW = cnt_width(SAMPLE_PERIOD);
  localparam logic [TW-1:0] LAST = TW'(SAMPLE_PERIOD - 1);

  logic [TW-1:0] r_cnt;

  // Free-running count 0..SAMPLE_PERIOD-1, advancing only while enabled.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/heart_row_serializer.sv
// Samples the heart row vector at a fixed period into a one-deep hold
// buffer and shifts each frame MSB-first to an external shift-register
// LED driver (sclk/sdata), finishing each frame with a latch pulse.
//
// Output timing: every output is a flop loaded from the next-state
// decode, so outputs line up with the FSM state of the same cycle and
// there is no combinational path from row_in to any pin.
// Serial interface: sdata is stable for a whole bit (2*CLK_DIV cycles);
// sclk is low for the first CLK_DIV cycles and high for the second, so
// the driver samples sdata on the sclk rising edge at mid-bit.
module heart_row_serializer
  import heart_pkg::*;
#(
  parameter int NUM_ROWS      = HEART_NUM_ROWS,
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_in,
  input  logic                enable,
  output logic                sclk,
  output logic                sdata,
  output logic                latch,
  output logic                busy,
  output logic                overrun,
  output logic [CNT_W-1:0]    frame_count,
  output logic [1:0]          dbg_state
);

  localparam int BIT_W = cnt_width(NUM_ROWS);
  localparam int DIV_W = cnt_width(2 * CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_ROWS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] SCLK_HI    = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(CLK_DIV - 1);

  state_t              r_state;
  state_t              w_nxt_state;
  logic [NUM_ROWS-1:0] r_hold;
  logic                r_hold_valid;
  logic [NUM_ROWS-1:0] r_shift;
  logic [NUM_ROWS-1:0] w_nxt_shift;
  logic [BIT_W-1:0]    r_bit_idx;
  logic [BIT_W-1:0]    w_nxt_bit;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    w_nxt_div;
  logic                w_frame_done;
  logic                w_tick;
  logic                w_nxt_sclk;
  logic                w_nxt_sdata;
  logic                r_sclk;
  logic                r_sdata;
  logic                r_latch;
  logic                r_busy;
  logic                r_overrun;
  logic [CNT_W-1:0]    r_frame_count;

  heart_sample_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_enable (enable),
    .o_tick   (w_tick)
  );

  // Hold buffer: a tick captures row_in when the buffer is empty or is
  // being drained by LOAD this very cycle; otherwise the sample is lost
  // and the sticky overrun flag records it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_tick && (!r_hold_valid || (r_state == ST_LOAD))) begin
        r_hold       <= row_in;
        r_hold_valid <= 1'b1;
      end else begin
        if (r_state == ST_LOAD) r_hold_valid <= 1'b0;
        if (w_tick)             r_overrun    <= 1'b1;
      end
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_div     <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_shift   <= w_nxt_shift;
      r_bit_idx <= w_nxt_bit;
      r_div     <= w_nxt_div;
    end
  end

  // Next-state decode: LOAD copies the hold buffer, SHIFT walks the bits
  // MSB-first with r_div timing each bit, LATCH reuses r_div for width.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_shift  = r_shift;
    w_nxt_bit    = r_bit_idx;
    w_nxt_div    = r_div;
    w_frame_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_hold_valid) w_nxt_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_nxt_shift = r_hold;
        w_nxt_bit   = BIT_LAST;
        w_nxt_div   = '0;
        w_nxt_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_nxt_div = '0;
          if (r_bit_idx == '0) w_nxt_state = ST_LATCH;
          else                 w_nxt_bit   = r_bit_idx - 1'b1;
        end else begin
          w_nxt_div = r_div + 1'b1;
        end
      end
      ST_LATCH: begin
        if (r_div == LATCH_LAST) begin
          w_nxt_div    = '0;
          w_nxt_state  = ST_IDLE;
          w_frame_done = 1'b1;
        end else begin
          w_nxt_div = r_div + 1'b1;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // Pin values for the coming cycle, derived from the next state.
  always_comb begin
    w_nxt_sclk  = 1'b0;
    w_nxt_sdata = 1'b0;
    if (w_nxt_state == ST_SHIFT) begin
      w_nxt_sclk  = (w_nxt_div >= SCLK_HI);
      w_nxt_sdata = w_nxt_shift[w_nxt_bit];
    end
  end

  // Registered outputs and the completed-frame counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sclk        <= 1'b0;
      r_sdata       <= 1'b0;
      r_latch       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_sclk  <= w_nxt_sclk;
      r_sdata <= w_nxt_sdata;
      r_latch <= (w_nxt_state == ST_LATCH);
      r_busy  <= (w_nxt_state != ST_IDLE);
      if (w_frame_done) r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign sclk        = r_sclk;
  assign sdata       = r_sdata;
  assign latch       = r_latch;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_heart_row_serializer.sv
// Bench for heart_row_serializer. Two instances share the inputs: u_dut0
// (CLK_DIV=2, SAMPLE_PERIOD=64, 4-bit count, frames fit the period) and
// u_dut1 (CLK_DIV=4, SAMPLE_PERIOD=32, frames longer than the period so
// samples get dropped). A frame-level timing model predicts every pin.
module tb_heart_row_serializer;

  localparam int N = 12;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [N-1:0] row_in;

  logic sclk0, sdata0, latch0, busy0, ovr0;
  logic sclk1, sdata1, latch1, busy1, ovr1;
  logic [3:0] fc0;
  logic [7:0] fc1;
  logic [1:0] st0, st1;

  heart_row_serializer #(.NUM_ROWS(N), .CLK_DIV(2), .SAMPLE_PERIOD(64), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset(reset), .row_in(row_in), .enable(enable),
    .sclk(sclk0), .sdata(sdata0), .latch(latch0), .busy(busy0),
    .overrun(ovr0), .frame_count(fc0), .dbg_state(st0)
  );

  heart_row_serializer #(.NUM_ROWS(N), .CLK_DIV(4), .SAMPLE_PERIOD(32), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .row_in(row_in), .enable(enable),
    .sclk(sclk1), .sdata(sdata1), .latch(latch1), .busy(busy1),
    .overrun(ovr1), .frame_count(fc1), .dbg_state(st1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_cd[2] = '{2, 4};
  int          m_sp[2] = '{64, 32};
  int          m_cw[2] = '{4, 8};
  int          m_timer[2];
  int          m_rem[2];     // cycles left in the current frame, 0 = idle
  bit          m_hv[2];
  logic [N-1:0] m_hold[2];
  logic [N-1:0] m_cur[2];
  bit          m_ovr[2];
  int          m_cnt[2];
  logic [N-1:0] exp_q0[$];
  logic [N-1:0] exp_q1[$];

  logic [N-1:0] mon_acc[2];
  int           mon_n[2];
  bit           mon_sclk_prev[2];
  bit           mon_latch_prev[2];
  logic [N-1:0] first_frame0;
  bit           first_seen0 = 1'b0;

  function automatic int frame_len(input int d);
    return 1 + 2 * m_cd[d] * N + m_cd[d];
  endfunction

  task automatic model_step(input int d, input logic rst_n, input logic en, input logic [N-1:0] row);
    int f;
    bit tick, loading, cap;
    f = frame_len(d);
    if (!rst_n) begin
      m_timer[d] = 0; m_rem[d] = 0; m_hv[d] = 0; m_hold[d] = '0;
      m_cur[d] = '0; m_ovr[d] = 0; m_cnt[d] = 0;
      mon_acc[d] = '0; mon_n[d] = 0;
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
    end else begin
      tick    = en && (m_timer[d] == m_sp[d] - 1);
      loading = (m_rem[d] == f);
      cap     = tick && (!m_hv[d] || loading);
      if (tick && !cap) m_ovr[d] = 1;
      if (m_rem[d] > 0) begin
        if (loading) begin
          m_cur[d] = m_hold[d];
          if (d == 0) exp_q0.push_back(m_hold[d]); else exp_q1.push_back(m_hold[d]);
        end
        m_rem[d]--;
        if (m_rem[d] == 0) m_cnt[d] = (m_cnt[d] + 1) % (1 << m_cw[d]);
      end else if (m_hv[d]) begin
        m_rem[d] = f;
      end
      if (cap) begin
        m_hold[d] = row;
        m_hv[d]   = 1;
      end else if (loading) begin
        m_hv[d] = 0;
      end
      if (en) m_timer[d] = (m_timer[d] + 1) % m_sp[d];
    end
  endtask

  // {sclk, sdata, latch, busy, overrun, frame_count[15:0]}
  function automatic logic [20:0] exp_outs(input int d);
    int f, k, j, b, cd;
    logic sc, sd, la;
    sc = 0; sd = 0; la = 0;
    cd = m_cd[d];
    f  = frame_len(d);
    if (m_rem[d] > 0) begin
      k = f - m_rem[d];
      if (k >= 1 && k <= 2 * cd * N) begin
        j  = k - 1;
        b  = N - 1 - j / (2 * cd);
        sc = ((j % (2 * cd)) >= cd);
        sd = m_cur[d][b];
      end else if (k > 2 * cd * N) begin
        la = 1;
      end
    end
    return {sc, sd, la, (m_rem[d] > 0), m_ovr[d], 16'(m_cnt[d])};
  endfunction

  always @(posedge clk) begin
    model_step(0, reset, enable, row_in);
    model_step(1, reset, enable, row_in);
  end

  // ---------------- scoreboard / monitor ----------------
  bit chk_en = 1'b0;

  task automatic monitor(input int d, input logic sc, input logic sd, input logic la);
    logic [N-1:0] e;
    int qs;
    if (sc && !mon_sclk_prev[d]) begin
      mon_acc[d] = {mon_acc[d][N-2:0], sd};
      mon_n[d]++;
    end
    if (la && !mon_latch_prev[d]) begin
      qs = (d == 0) ? exp_q0.size() : exp_q1.size();
      check($sformatf("frame_bits_d%0d", d), 64'(mon_n[d]), 64'(N));
      check($sformatf("frame_avail_d%0d", d), 64'(qs > 0), 64'd1);
      if (qs > 0) begin
        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("frame_data_d%0d", d), 64'(mon_acc[d]), 64'(e));
      end
      if (d == 0 && !first_seen0) begin
        first_frame0 = mon_acc[d];
        first_seen0  = 1'b1;
      end
      mon_acc[d] = '0;
      mon_n[d]   = 0;
    end
    mon_sclk_prev[d]  = sc;
    mon_latch_prev[d] = la;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pins_d0", 64'({sclk0, sdata0, latch0, busy0, ovr0, 12'd0, fc0}), 64'(exp_outs(0)));
      check("pins_d1", 64'({sclk1, sdata1, latch1, busy1, ovr1, 8'd0, fc1}), 64'(exp_outs(1)));
      monitor(0, sclk0, sdata0, latch0);
      monitor(1, sclk1, sdata1, latch1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_random(input int cycles, input int en_pct);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      row_in = N'($urandom_range(0, (1 << N) - 1));
      enable = ($urandom_range(0, 99) < en_pct);
    end
  endtask

  task automatic run_hold(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mon_sclk_prev  = '{0, 0};
    mon_latch_prev = '{0, 0};
    mon_acc        = '{'0, '0};
    mon_n          = '{0, 0};
    reset  = 1'b0;
    enable = 1'b1;
    row_in = N'($urandom_range(0, (1 << N) - 1));
    @(posedge clk);
    chk_en = 1'b1;

    // Reset held with enable high and changing rows: nothing moves.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      row_in = N'($urandom_range(0, (1 << N) - 1));
    end
    check("rst_pins_d0", 64'({sclk0, sdata0, latch0, busy0, ovr0, fc0}), 64'd0);
    check("rst_pins_d1", 64'({sclk1, sdata1, latch1, busy1, ovr1, fc1}), 64'd0);

    // Known pattern frame.
    reset  = 1'b1;
    row_in = 12'hA5C;
    enable = 1'b1;
    run_hold(200);
    check("first_frame_a5c", 64'(first_frame0), 64'h0A5C);
    check("first_frame_seen", 64'(first_seen0), 64'd1);
    check("overrun_d1_set", 64'(ovr1), 64'd1);

    // Random rows with occasional enable gaps; dut0 counter wraps.
    run_random(1500, 95);

    // Enable dropped for a long stretch: in-flight work drains, then quiet.
    enable = 1'b0;
    run_hold(1000);
    check("quiet_busy_d0", 64'(busy0), 64'd0);
    check("quiet_busy_d1", 64'(busy1), 64'd0);
    enable = 1'b1;
    run_random(300, 100);

    // Reset in the middle of a shift.
    for (int i = 0; i < 200 && !(busy0 && st0 == 2'd2); i++) @(negedge clk);
    check("busy_wait_d0", 64'(busy0), 64'd1);
    run_hold(2 * 2 * 5);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_pins_d0", 64'({sclk0, sdata0, latch0, busy0, ovr0, fc0}), 64'd0);
    check("midrst_pins_d1", 64'({sclk1, sdata1, latch1, busy1, ovr1, fc1}), 64'd0);
    run_hold(2);
    reset = 1'b1;

    // Fresh random run, then drain with enable low.
    run_random(800, 100);
    enable = 1'b0;
    run_hold(300);
    check("drained_q0", 64'(exp_q0.size()), 64'd0);
    check("drained_q1", 64'(exp_q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
